// File: rtl/sync_sram.sv
// ----------------------------------------------------------------------------
// sync_sram
//
// Single-port synchronous SRAM with a valid/ready request interface, byte
// enables, a configurable read latency and a self-clearing startup sweep.
//
// After reset, the block spends DEPTH cycles writing zero to every word.
// During that time req_ready and init_done are low.
// After the sweep it accepts one request per cycle.
//
// Out-of-range accesses (req_addr >= DEPTH) behave as follows:
//   - writes are dropped;
//   - reads return zero data with rsp_err set.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   req_valid  : request present
//   req_ready  : request can be accepted (READY state)
//   req_we     : 1 = write, 0 = read
//   req_addr   : word address
//   req_wdata  : write data
//   req_be     : byte enables, bit i covers data bits [8i+7:8i]
//   rsp_valid  : read response valid, one cycle per read
//   rsp_rdata  : read data, holds its value between responses
//   rsp_err    : read address out of range, qualified by rsp_valid
//   init_done  : clear sweep complete
// ----------------------------------------------------------------------------
//  state    | meaning
//  ---------+-----------------------------------------------------
//  ST_INIT  | zeroing mem[ptr] each cycle, requests ignored
//  ST_READY | normal operation, one request accepted per cycle
// ----------------------------------------------------------------------------
module sync_sram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_done
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    // One extra bit so DEPTH == 2**ADDR_W is representable in the range check.
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic              mem_clr;

    logic              accept;
    logic              addr_ok;
    logic              wr_en;
    logic              rd_en;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              s1_valid;
    logic              s1_err;
    logic [DATA_W-1:0] s1_data;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        req_ready = 1'b0;
        mem_clr   = 1'b0;
        case (state)
            ST_INIT: begin
                mem_clr = 1'b1;
                ptr_nxt = ptr + 1'b1;
                if (ptr == PTR_LAST) begin
                    state_nxt = ST_READY;
                    ptr_nxt   = '0;
                end
            end
            ST_READY: begin
                req_ready = 1'b1;
            end
            default: begin
                state_nxt = ST_INIT;
                ptr_nxt   = '0;
            end
        endcase
    end

    assign init_done = req_ready;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign accept  = req_valid & req_ready;
    assign addr_ok = ({1'b0, req_addr} < DEPTH_W);
    assign wr_en   = accept & req_we & addr_ok;
    assign rd_en   = accept & ~req_we;

    // ------------------------------------------------------------------
    // Storage. No reset: the INIT sweep is the only clear path.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_clr) begin
            mem[ptr] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (req_be[b]) begin
                    mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read stage 1.
    // Writes commit at their own edge, so a read on the next edge already
    // sees them. No bypass path is needed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_en;
            s1_err   <= rd_en & ~addr_ok;
            if (rd_en) begin
                s1_data <= addr_ok ? mem[req_addr] : '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional second stage for RD_LAT == 2
    // ------------------------------------------------------------------
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s2_valid;
            logic              s2_err;
            logic [DATA_W-1:0] s2_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_valid <= 1'b0;
                    s2_err   <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    s2_err   <= s1_err;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign rsp_valid = s2_valid;
            assign rsp_err   = s2_err;
            assign rsp_rdata = s2_data;
        end else begin : g_lat1
            assign rsp_valid = s1_valid;
            assign rsp_err   = s1_err;
            assign rsp_rdata = s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_sync_sram.sv
// ----------------------------------------------------------------------------
// tb_sync_sram
//
// Three instances share one request bus:
//   dut0 : defaults (RD_LAT = 1)
//   dut1 : RD_LAT = 2
//   dut2 : DEPTH = 1000, ADDR_W = 10
//
// A vector table is streamed back-to-back. Responses are compared every
// cycle at both latencies. Startup, out-of-range and reset-in-flight cases
// use hand-written sequences.
// ----------------------------------------------------------------------------
module tb_sync_sram;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [10:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;

    logic        rdy0, v0, e0, id0;
    logic [15:0] rd0;
    logic        rdy1, v1, e1, id1;
    logic [15:0] rd1;
    logic        rdy2, v2, e2, id2;
    logic [15:0] rd2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sync_sram dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_be(req_be), .rsp_valid(v0), .rsp_rdata(rd0), .rsp_err(e0),
        .init_done(id0)
    );

    sync_sram #(.RD_LAT(2)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_be(req_be), .rsp_valid(v1), .rsp_rdata(rd1), .rsp_err(e1),
        .init_done(id1)
    );

    sync_sram #(.DEPTH(1000), .ADDR_W(10)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy2),
        .req_we(req_we), .req_addr(req_addr[9:0]), .req_wdata(req_wdata),
        .req_be(req_be), .rsp_valid(v2), .rsp_rdata(rd2), .rsp_err(e2),
        .init_done(id2)
    );

    typedef struct {
        logic        we;
        logic [10:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] exp;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [10:0] a,
                         input logic [15:0] d, input logic [1:0] be);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
    endtask

    task automatic add(input logic we, input logic [10:0] a, input logic [15:0] d,
                       input logic [1:0] be, input logic [15:0] exp, input logic err);
        vec_t t;
        t.we = we; t.addr = a; t.wdata = d; t.be = be; t.exp = exp; t.exp_err = err;
        vecs.push_back(t);
    endtask

    task automatic chk_rsp(input string name, input logic v, input logic [15:0] rd,
                           input logic e, input vec_t t);
        chk({name, "_valid"}, v, !t.we);
        if (!t.we) begin
            chk({name, "_rdata"}, rd, t.exp);
            chk({name, "_err"}, e, t.exp_err);
        end else begin
            chk({name, "_err_idle"}, e, 1'b0);
        end
    endtask

    // Returns the cycle on which dut0/dut1 reach READY (and dut2 separately).
    // Returns -1 if the cycle budget expires.
    task automatic wait_ready(output int r0, output int r1, output int r2);
        r0 = -1; r1 = -1; r2 = -1;
        for (int cyc = 1; cyc <= 2200; cyc++) begin
            @(posedge clk); #1;
            if (r0 < 0 && rdy0) r0 = cyc;
            if (r1 < 0 && rdy1) r1 = cyc;
            if (r2 < 0 && rdy2) r2 = cyc;
            if (r0 >= 0 && r1 >= 0) break;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, r1, r2;
        int n;

        // Vector table: consecutive requests, expected read data hand-computed.
        add(0, 11'd3,     16'h0000, 2'b11, 16'hBEEF, 0); // written on first READY cycle
        add(0, 11'h7FF,   16'h0000, 2'b11, 16'h0000, 0); // last word cleared
        add(1, 11'd5,     16'h1234, 2'b11, 16'h0000, 0);
        add(1, 11'd5,     16'hAB00, 2'b10, 16'h0000, 0);
        add(0, 11'd5,     16'h0000, 2'b11, 16'hAB34, 0); // merged bytes, RAW next cycle
        add(1, 11'd0,     16'h00A0, 2'b11, 16'h0000, 0);
        add(1, 11'd1,     16'h00A1, 2'b11, 16'h0000, 0);
        add(1, 11'd2,     16'h00A2, 2'b11, 16'h0000, 0);
        add(1, 11'd3,     16'h00A3, 2'b11, 16'h0000, 0);
        add(0, 11'd3,     16'h0000, 2'b11, 16'h00A3, 0);
        add(0, 11'd2,     16'h0000, 2'b11, 16'h00A2, 0);
        add(0, 11'd1,     16'h0000, 2'b11, 16'h00A1, 0);
        add(0, 11'd0,     16'h0000, 2'b11, 16'h00A0, 0);
        add(1, 11'd6,     16'hFFFF, 2'b00, 16'h0000, 0); // no bytes enabled
        add(0, 11'd6,     16'h0000, 2'b11, 16'h0000, 0);
        add(1, 11'd8,     16'hABCD, 2'b01, 16'h0000, 0);
        add(0, 11'd8,     16'h0000, 2'b11, 16'h00CD, 0);
        n = vecs.size();

        // ---------------- reset and startup sweep ----------------
        rst = 1'b1;
        drive(1, 1, 11'd3, 16'hBEEF, 2'b11);   // held through INIT
        #2;
        chk("rst_ready",     rdy0, 1'b0);
        chk("rst_init_done", id0,  1'b0);
        chk("rst_valid0",    v0,   1'b0);
        chk("rst_rdata0",    rd0,  16'h0);
        chk("rst_err0",      e0,   1'b0);
        chk("rst_valid1",    v1,   1'b0);
        chk("rst_rdata1",    rd1,  16'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_ready(r0, r1, r2);
        chk("init_cycles_lat1", r0, 2048);
        chk("init_cycles_lat2", r1, 2048);
        chk("init_cycles_d1000", r2, 1000);
        chk("init_done_ready", id0, 1'b1);
        @(posedge clk);                         // first READY edge accepts the held write
        @(negedge clk);
        drive(0, 0, 11'd0, 16'h0, 2'b00);

        // ---------------- table, back-to-back ----------------
        for (int i = 0; i <= n + 1; i++) begin
            @(negedge clk);
            if (i < n) drive(1, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
            else       drive(0, 0, 11'd0, 16'h0, 2'b00);
            @(posedge clk); #1;
            if (i < n) chk_rsp($sformatf("tbl_l1_%0d", i), v0, rd0, e0, vecs[i]);
            else       chk("tbl_l1_tail_valid", v0, 1'b0);
            if (i >= 1 && i - 1 < n) chk_rsp($sformatf("tbl_l2_%0d", i - 1), v1, rd1, e1, vecs[i - 1]);
            else                     chk("tbl_l2_edge_valid", v1, 1'b0);
        end

        // ---------------- out-of-range on DEPTH=1000 ----------------
        @(negedge clk);
        drive(1, 1, 11'd1000, 16'hFFFF, 2'b11);
        @(negedge clk);
        drive(1, 0, 11'd1000, 16'h0, 2'b11);
        @(posedge clk); #1;
        chk("oor_valid", v2,  1'b1);
        chk("oor_rdata", rd2, 16'h0);
        chk("oor_err",   e2,  1'b1);
        chk("inr_1000_lat1", rd0, 16'hFFFF);
        @(negedge clk);
        drive(1, 0, 11'd999, 16'h0, 2'b11);
        @(posedge clk); #1;
        chk("last_valid", v2,  1'b1);
        chk("last_err",   e2,  1'b0);
        chk("last_rdata", rd2, 16'h0);
        @(negedge clk);
        drive(0, 0, 11'd0, 16'h0, 2'b00);
        @(posedge clk); #1;
        chk("idle_valid2", v2, 1'b0);
        chk("idle_err2",   e2, 1'b0);

        // ---------------- reset with a read in flight ----------------
        @(negedge clk);
        drive(1, 1, 11'd7, 16'h5555, 2'b11);
        @(negedge clk);
        drive(1, 0, 11'd7, 16'h0, 2'b11);
        @(posedge clk); #1;
        chk("flight_l1_rdata", rd0, 16'h5555);
        chk("flight_l2_valid", v1, 1'b0);
        #1;
        rst = 1'b1;
        drive(0, 0, 11'd0, 16'h0, 2'b00);
        #1;
        chk("arst_valid0", v0,   1'b0);
        chk("arst_rdata0", rd0,  16'h0);
        chk("arst_valid1", v1,   1'b0);
        chk("arst_ready",  rdy0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("rst_hold_valid1", v1, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_ready(r0, r1, r2);
        chk("reinit_cycles", r0, 2048);
        @(negedge clk);
        drive(1, 0, 11'd7, 16'h0, 2'b11);
        @(posedge clk); #1;
        chk("reinit_valid0", v0,  1'b1);
        chk("reinit_rdata0", rd0, 16'h0);
        chk("reinit_l2_pending", v1, 1'b0);
        @(negedge clk);
        drive(0, 0, 11'd0, 16'h0, 2'b00);
        @(posedge clk); #1;
        chk("reinit_valid1", v1,  1'b1);
        chk("reinit_rdata1", rd1, 16'h0);
        chk("reinit_l1_done", v0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_sram.md
SYNC_SRAM -- requirements
Module: sync_sram

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, word width in bits; legal values are multiples of 8.
REQ-002 SHALL provide parameter ADDR_W, default 11, address width in bits.
REQ-003 SHALL provide parameter DEPTH, default 2048, number of words; legal range is 1 to 2**ADDR_W.
REQ-004 SHALL provide parameter RD_LAT, default 1, read latency in cycles; legal values are 1 and 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port req_valid, input, 1 bit: a request is presented.
REQ-008 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-009 SHALL have port req_we, input, 1 bit: 1 selects write, 0 selects read.
REQ-010 SHALL have port req_addr, input, ADDR_W bits: word address.
REQ-011 SHALL have port req_wdata, input, DATA_W bits: write data.
REQ-012 SHALL have port req_be, input, DATA_W/8 bits: byte enables; bit i covers data bits [8i+7:8i].
REQ-013 SHALL have port rsp_valid, output, 1 bit: read response is present this cycle.
REQ-014 SHALL have port rsp_rdata, output, DATA_W bits: read data.
REQ-015 SHALL have port rsp_err, output, 1 bit: the read address was out of range; qualified by rsp_valid.
REQ-016 SHALL have port init_done, output, 1 bit: memory clear is complete.

Function
REQ-017 SHALL implement the two-state FSM INIT -> READY; reset forces INIT with clear pointer 0.
REQ-018 In INIT, SHALL write all-zero to address ptr each cycle and increment ptr; after the write to DEPTH-1, the next state SHALL be READY, so INIT lasts exactly DEPTH cycles.
REQ-019 SHALL drive req_ready = init_done = 1 only in READY; in INIT, requests SHALL be ignored and not queued.
REQ-020 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; the block SHALL accept one request per cycle with no bubbles.
REQ-021 On an accepted write, only the bytes with req_be set SHALL be updated at that edge; req_be = 0 SHALL leave memory unchanged.
REQ-022 Writes SHALL produce no response: no rsp_valid pulse for a write.
REQ-023 An accepted read SHALL raise rsp_valid for exactly one cycle, RD_LAT cycles after the accept edge; reads are fully pipelined and responses are returned in order.
REQ-024 Read data SHALL reflect every write accepted before the read's accept edge, including a write in the immediately preceding cycle.
REQ-025 When req_addr >= DEPTH: writes SHALL be dropped; reads SHALL return rsp_rdata = 0 with rsp_err = 1.
REQ-026 While rsp_valid = 0, rsp_rdata SHALL hold its last value and rsp_err SHALL be 0.
REQ-027 The memory array SHALL NOT be reset directly; the INIT sweep is the only clear mechanism.

Reset
REQ-028 On rst = 1, without waiting for clk, SHALL set: req_ready = 0, init_done = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, FSM = INIT, ptr = 0, and flush the read pipeline.
REQ-029 A reset asserted during INIT or READY SHALL restart the full DEPTH-cycle clear; reads in flight SHALL be discarded with no response.

Verification
REQ-030 Defaults, release reset -> req_ready = 0 for exactly 2048 cycles, then 1; a read of addr 0x7FF then returns 0x0000 with rsp_err = 0.
REQ-031 Write 0x1234 to 5 with be = 11, then write 0xAB00 to 5 with be = 10, then read 5 -> 0xAB34 one cycle after the read accept.
REQ-032 Back-to-back writes of 0xA0+n to addr n for n = 0..3, then reads of addr 3,2,1,0 in consecutive cycles -> rsp_valid high 4 consecutive cycles, data 0xA3,0xA2,0xA1,0xA0; repeat with RD_LAT = 2 and check the 2-cycle offset.
REQ-033 DEPTH = 1000, ADDR_W = 10: write 0xFFFF to 1000, then read 1000 -> rsp_rdata = 0 and rsp_err = 1; a read of 999 -> rsp_err = 0.
REQ-034 Write 0x5555 to 7, then assert rst mid-stream while a read of 7 is in flight -> no rsp_valid; after a new 2048-cycle INIT, a read of 7 returns 0x0000.
REQ-035 Hold req_valid = 1 for a write to 3 with data 0xBEEF throughout INIT -> no write occurs before READY; the first accept happens on the first READY cycle.
